// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 transmit path: mode encodings, scheduler
// state encodings and the packet-count helper.
package tlk2711_pkg;

  localparam logic [3:0] MODE_NORM  = 4'd0;
  localparam logic [3:0] MODE_LOOP  = 4'd1;
  localparam logic [3:0] MODE_KCODE = 4'd2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_CHECK = S_CHECK,
    ST_ISSUE = S_ISSUE,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_e;

  // Body packets plus one optional tail packet.
  function automatic logic [16:0] pkt_count(input logic [15:0] num,
                                            input logic [15:0] tail);
    return {1'b0, num} + {16'd0, (tail != '0)};
  endfunction

endpackage

// File: rtl/tlk2711_pkt_addr_gen.sv
// Running per-packet address/length/last generator. Load primes packet 0,
// advance steps to the next packet on each accepted command.
module tlk2711_pkt_addr_gen
  import tlk2711_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [15:0]           body,
  input  logic [15:0]           num,
  input  logic [15:0]           tail,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [15:0]           len,
  output logic                  last
);

  logic [16:0] idx;
  logic [16:0] idx_nxt;
  logic [16:0] n_pkts;

  assign n_pkts  = pkt_count(num, tail);
  assign idx_nxt = idx + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      addr <= '0;
      len  <= '0;
      last <= 1'b0;
    end else if (load) begin
      idx  <= '0;
      addr <= base;
      len  <= (num != '0) ? body : tail;
      last <= (n_pkts == 17'd1);
    end else if (advance) begin
      // Outputs describe the packet that will be offered next.
      idx  <= idx_nxt;
      addr <= addr + ADDR_WIDTH'(body);
      len  <= (idx_nxt < {1'b0, num}) ? body : tail;
      last <= ((idx_nxt + 17'd1) == n_pkts);
    end
  end

endmodule

// File: rtl/tlk2711_tx_sched.sv
// TLK2711 transmit scheduler: validates the TX config, issues per-packet DDR
// read commands with an outstanding limit and pulses the completion interrupt.
module tlk2711_tx_sched
  import tlk2711_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
  input  logic [31:0]           i_tx_total_packet,
  input  logic [15:0]           i_tx_packet_body,
  input  logic [15:0]           i_tx_body_num,
  input  logic [15:0]           i_tx_packet_tail,
  input  logic [3:0]            i_tx_mode,
  input  logic                  i_tx_config_done,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [ADDR_WIDTH-1:0] o_cmd_addr,
  output logic [15:0]           o_cmd_len,
  output logic                  o_cmd_last,
  input  logic                  i_pkt_done,
  output logic [3:0]            o_tx_mode,
  output logic                  o_kcode_en,
  output logic                  o_busy,
  output logic                  o_cfg_err,
  output logic                  o_tx_interrupt
);

  localparam int unsigned     OW      = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);

  state_e                state;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [31:0]           cfg_total;
  logic [15:0]           cfg_body;
  logic [15:0]           cfg_num;
  logic [15:0]           cfg_tail;
  logic [3:0]            cfg_mode;
  logic [16:0]           n_pkts;
  logic [16:0]           issued;
  logic [16:0]           completed;
  logic [OW-1:0]         outstanding;
  logic [33:0]           expect_total;
  logic                  accept;
  logic                  done_ok;

  assign n_pkts       = pkt_count(cfg_num, cfg_tail);
  assign expect_total = 34'(cfg_body) * 34'(cfg_num) + 34'(cfg_tail);

  assign o_cmd_valid = (state == ST_ISSUE) && (issued < n_pkts) && (outstanding < MAX_OUT);
  assign accept      = o_cmd_valid & i_cmd_ready;
  assign done_ok     = i_pkt_done && (outstanding != '0);
  assign o_busy      = (state != ST_IDLE);
  assign o_tx_mode   = cfg_mode;

  tlk2711_pkt_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_CHECK),
    .advance (accept),
    .base    (cfg_base),
    .body    (cfg_body),
    .num     (cfg_num),
    .tail    (cfg_tail),
    .addr    (o_cmd_addr),
    .len     (o_cmd_len),
    .last    (o_cmd_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cfg_base       <= '0;
      cfg_total      <= '0;
      cfg_body       <= '0;
      cfg_num        <= '0;
      cfg_tail       <= '0;
      cfg_mode       <= '0;
      issued         <= '0;
      completed      <= '0;
      outstanding    <= '0;
      o_kcode_en     <= 1'b0;
      o_cfg_err      <= 1'b0;
      o_tx_interrupt <= 1'b0;
    end else begin
      o_tx_interrupt <= 1'b0;
      if (accept)  issued    <= issued + 17'd1;
      if (done_ok) completed <= completed + 17'd1;
      if (accept != done_ok)
        outstanding <= accept ? outstanding + OW'(1) : outstanding - OW'(1);

      case (state)
        ST_IDLE: begin
          if (i_tx_config_done) begin
            cfg_base   <= i_tx_base_addr;
            cfg_total  <= i_tx_total_packet;
            cfg_body   <= i_tx_packet_body;
            cfg_num    <= i_tx_body_num;
            cfg_tail   <= i_tx_packet_tail;
            cfg_mode   <= i_tx_mode;
            o_cfg_err  <= 1'b0;
            o_kcode_en <= 1'b0;
            issued     <= '0;
            completed  <= '0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ((expect_total != {2'b00, cfg_total}) || (cfg_mode > MODE_KCODE)) begin
            o_cfg_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (cfg_mode == MODE_KCODE) begin
            o_kcode_en <= 1'b1;
            state      <= ST_IDLE;
          end else if (n_pkts == '0) begin
            state <= ST_DONE;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept && ((issued + 17'd1) == n_pkts)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Count this cycle's completion so the interrupt lands two cycles later.
          if ((completed + 17'(done_ok)) == n_pkts) state <= ST_DONE;
        end
        ST_DONE: begin
          o_tx_interrupt <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (i_tx_config_done && (state != ST_IDLE)) o_cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// Directed and randomized bench for tlk2711_tx_sched against a transfer-level
// reference model (command list computed as base + k*body).
module tb_tlk2711_tx_sched;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] base = '0;
  logic [31:0] total = '0;
  logic [15:0] body = '0;
  logic [15:0] num = '0;
  logic [15:0] tail = '0;
  logic [3:0]  mode = '0;
  logic        cfg_done = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        pkt_done = 1'b0;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_last;
  logic [3:0]  tx_mode;
  logic        kcode_en;
  logic        busy;
  logic        cfg_err;
  logic        tx_int;

  int          passed = 0;
  int          checks = 0;
  int          cyc = 0;
  int          c0 = 0;
  logic [31:0] m_base;
  logic [15:0] m_body;
  logic [15:0] m_num;
  logic [15:0] m_tail;
  logic [3:0]  m_mode;
  logic [31:0] r_base;
  logic [15:0] r_body;
  logic [15:0] r_num;
  logic [15:0] r_tail;

  always #5 clk = ~clk;

  tlk2711_tx_sched #(
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_tx_base_addr    (base),
    .i_tx_total_packet (total),
    .i_tx_packet_body  (body),
    .i_tx_body_num     (num),
    .i_tx_packet_tail  (tail),
    .i_tx_mode         (mode),
    .i_tx_config_done  (cfg_done),
    .o_cmd_valid       (cmd_valid),
    .i_cmd_ready       (cmd_ready),
    .o_cmd_addr        (cmd_addr),
    .o_cmd_len         (cmd_len),
    .o_cmd_last        (cmd_last),
    .i_pkt_done        (pkt_done),
    .o_tx_mode         (tx_mode),
    .o_kcode_en        (kcode_en),
    .o_busy            (busy),
    .o_cfg_err         (cfg_err),
    .o_tx_interrupt    (tx_int)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_addr"},  cmd_addr,  0);
    chk({tag, "_len"},   cmd_len,   0);
    chk({tag, "_last"},  cmd_last,  0);
    chk({tag, "_mode"},  tx_mode,   0);
    chk({tag, "_kcode"}, kcode_en,  0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_err"},   cfg_err,   0);
    chk({tag, "_int"},   tx_int,    0);
  endtask

  // Drives config_done for one cycle (cycle C); returns at cycle C+1.
  task automatic start(input logic [31:0] b, input logic [31:0] t, input logic [15:0] bd,
                       input logic [15:0] n, input logic [15:0] tl, input logic [3:0] md);
    base = b; total = t; body = bd; num = n; tail = tl; mode = md;
    m_base = b; m_body = bd; m_num = n; m_tail = tl; m_mode = md;
    cfg_done = 1'b1;
    c0 = cyc;
    tick();
    cfg_done = 1'b0;
  endtask

  task automatic quiet_cycles(input string tag, input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      tick();
      chk({tag, "_valid"}, cmd_valid, 0);
      chk({tag, "_int"},   tx_int,    0);
    end
  endtask

  // Runs an accepted transfer from cycle C+1 to its interrupt, checking every cycle.
  task automatic run_xfer(input int unsigned ready_pct, input int unsigned hold,
                          input int unsigned inj_at);
    int unsigned n;
    int unsigned issued;
    int unsigned pend;
    int unsigned done_cnt;
    int          due;
    bit          err_exp;
    bit          ev;
    logic [31:0] ea;
    logic [15:0] el;
    n        = m_num + ((m_tail != 0) ? 1 : 0);
    issued   = 0;
    pend     = 0;
    done_cnt = 0;
    err_exp  = 1'b0;
    due      = (n == 0) ? c0 + 3 : -1;
    chk("check_busy", busy, 1);
    chk("check_kcode", kcode_en, 0);
    for (int unsigned i = 0; i < 3000; i++) begin
      tick();
      cmd_ready = ($urandom_range(99) < ready_pct);
      pkt_done  = (pend > 0) && (i >= hold) && ($urandom_range(1) == 0);
      cfg_done  = (inj_at != 0) && (i == inj_at);
      if (cfg_done) begin
        base = ~base; total = 32'hdead; body = body + 16'd1; num = num + 16'd3; mode = 4'd2;
      end
      if ((hold != 0) && (i == hold)) chk("hold_issued", issued, MAXO);
      ev = (issued < n) && (pend < MAXO);
      chk("cmd_valid", cmd_valid, ev);
      if (ev) begin
        ea = m_base + 32'(issued) * 32'(m_body);
        el = (issued < m_num) ? m_body : m_tail;
        chk("cmd_addr", cmd_addr, ea);
        chk("cmd_len",  cmd_len,  el);
        chk("cmd_last", cmd_last, issued == n - 1);
      end
      chk("tx_mode",   tx_mode, m_mode);
      chk("interrupt", tx_int,  cyc == due);
      chk("busy",      busy,    (due < 0) || (cyc < due));
      chk("cfg_err",   cfg_err, err_exp);
      if (cyc == due) break;
      if (pkt_done) begin
        pend--;
        done_cnt++;
        if (done_cnt == n) due = cyc + 2;
      end
      if (ev && cmd_ready) begin
        issued++;
        pend++;
      end
      if ((inj_at != 0) && (i == inj_at)) err_exp = 1'b1;
    end
    chk("completion", cyc, due);
    cmd_ready = 1'b0;
    pkt_done  = 1'b0;
    cfg_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();
    chk_reset_vals("post_rst");

    // Reference transfer: 3 bodies of 870 plus a 100-byte tail.
    start(32'h1000_0000, 32'd2710, 16'd870, 16'd3, 16'd100, 4'd0);
    run_xfer(100, 0, 0);

    // Completions withheld: only MAXO commands may be outstanding.
    start(32'h1000_0000, 32'd2710, 16'd870, 16'd3, 16'd100, 4'd0);
    run_xfer(100, 8, 0);

    // Length mismatch.
    start(32'h1000_0000, 32'd2711, 16'd870, 16'd3, 16'd100, 4'd0);
    chk("mm_busy_c1", busy, 1);
    tick();
    chk("mm_busy_c2", busy, 0);
    chk("mm_err", cfg_err, 1);
    quiet_cycles("mm", 4);

    // K-code idle mode, then a normal config clears kcode_en.
    start(32'h1000_0000, 32'd2710, 16'd870, 16'd3, 16'd100, 4'd2);
    tick();
    chk("kc_en", kcode_en, 1);
    chk("kc_mode", tx_mode, 2);
    chk("kc_busy", busy, 0);
    chk("kc_err", cfg_err, 0);
    quiet_cycles("kc", 4);
    start(32'h2000_0000, 32'd1300, 16'd500, 16'd2, 16'd300, 4'd1);
    run_xfer(100, 0, 0);

    // Zero-packet transfer.
    start(32'h0000_4000, 32'd0, 16'd500, 16'd0, 16'd0, 4'd0);
    run_xfer(100, 0, 0);

    // Random configs with backpressure; odd runs inject a config_done mid-transfer.
    for (int unsigned it = 0; it < 10; it++) begin
      r_base = $urandom;
      r_body = 16'($urandom_range(1500, 1));
      r_num  = 16'($urandom_range(5, 0));
      r_tail = ($urandom_range(1) == 0) ? 16'd0 : 16'($urandom_range(1000, 1));
      if (r_num == 0 && r_tail == 0) r_tail = 16'd64;
      start(r_base, 32'(r_body) * 32'(r_num) + 32'(r_tail), r_body, r_num, r_tail,
            4'($urandom_range(1, 0)));
      run_xfer(60, 0, (it % 2 == 1) ? 2 : 0);
    end

    // Address wrap, then reset mid-transfer.
    start(32'hFFFF_FE00, 32'd1740, 16'd870, 16'd2, 16'd0, 4'd0);
    tick();
    cmd_ready = 1'b1;
    chk("wrap_valid0", cmd_valid, 1);
    chk("wrap_addr0", cmd_addr, 32'hFFFF_FE00);
    chk("wrap_len0", cmd_len, 870);
    chk("wrap_last0", cmd_last, 0);
    tick();
    cmd_ready = 1'b0;
    chk("wrap_valid1", cmd_valid, 1);
    chk("wrap_addr1", cmd_addr, 32'h0000_0166);
    chk("wrap_last1", cmd_last, 1);
    rst = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    tick();
    chk("after_rst_busy", busy, 0);
    chk("after_rst_valid", cmd_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tlk2711_tx_sched.md
# tlk2711_tx_sched

Transmit packet scheduler for the TLK2711 link. It consumes the TX configuration produced by the register manager: base address, total length, body size, body count, tail size, mode and the config-done strobe. It splits the transfer into per-packet DDR read commands for the TX datamover and tracks per-packet completion from the framer. When the whole file has been sent it returns the one-cycle `tx_interrupt` pulse to the register manager.

## Interface
- ADDR_WIDTH, 32, DDR byte-address width
- MAX_OUTSTANDING, 4, max issued-but-not-completed packets (power of 2, ≥1)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- i_tx_base_addr  in  ADDR_WIDTH  first packet byte address
- i_tx_total_packet  in  32  total bytes
- i_tx_packet_body  in  16  body packet length, bytes
- i_tx_body_num  in  16  number of body packets
- i_tx_packet_tail  in  16  tail packet length, bytes (0 = none)
- i_tx_mode  in  4  0 normal, 1 loopback, 2 kcode, other reserved
- i_tx_config_done  in  1  one-cycle start strobe
- o_cmd_valid  out  1  DMA read command valid
- i_cmd_ready  in  1  datamover accepts command
- o_cmd_addr  out  ADDR_WIDTH  command byte address
- o_cmd_len  out  16  command byte length
- o_cmd_last  out  1  command is the final packet
- i_pkt_done  in  1  framer finished one packet (pulse)
- o_tx_mode  out  4  latched mode for framer/PHY mux
- o_kcode_en  out  1  idle-kcode transmission enable
- o_busy  out  1  transfer in progress
- o_cfg_err  out  1  sticky configuration error
- o_tx_interrupt  out  1  transfer complete pulse

## Operation
- States: IDLE, CHECK, ISSUE, DRAIN, DONE.
- IDLE + i_tx_config_done:
  - latch all config inputs;
  - clear o_cfg_err;
  - go to CHECK.
- CHECK, one cycle, compares body*body_num + tail (34-bit) against total:
  - Mismatch, or mode > 2: o_cfg_err←1, go to IDLE.
  - Mode 2: o_kcode_en←1, go to IDLE, no commands and no interrupt. o_kcode_en clears on the next accepted config_done or on rst.
  - Packet count 0 (body_num=0, tail=0): go to DONE.
  - Otherwise: go to ISSUE.
- Packet count N = body_num + (tail≠0).
- ISSUE command rules:
  - o_cmd_valid=1 while issued<N and outstanding<MAX_OUTSTANDING.
  - Command k (0-based): addr = base + k*body, produced by a running adder, wrapping mod 2^ADDR_WIDTH.
  - len = body for k<body_num, else tail.
  - o_cmd_last=1 on command N-1.
- Handshake: a command transfers on o_cmd_valid & i_cmd_ready. Once valid is high, addr/len/last stay stable until accepted.
- Outstanding counter: +1 on accept, −1 on i_pkt_done, both in the same cycle → unchanged. An i_pkt_done with outstanding=0 is ignored.
- After the last accept, go to DRAIN.
- DRAIN: when completed==N, go to DONE.
- DONE: o_tx_interrupt=1 for exactly one cycle, then IDLE.
- i_tx_config_done while o_busy: ignored, config unchanged, o_cfg_err←1.
- o_busy = state ≠ IDLE.

## Timing
- Reset values: o_cmd_valid 0, o_cmd_addr 0, o_cmd_len 0, o_cmd_last 0, o_tx_mode 0, o_kcode_en 0, o_busy 0, o_cfg_err 0, o_tx_interrupt 0. Counters 0, state IDLE.
- Start latency: config_done high in cycle C → CHECK in C+1 → first o_cmd_valid in C+2.
- Command throughput: back-to-back, 1 command per cycle when ready is held high.
- Completion latency: i_pkt_done for the final packet in cycle D → o_tx_interrupt in D+2 (DRAIN→DONE, then pulse).
- Zero-packet config: interrupt in C+3.
- Same-cycle i_pkt_done and accept: handled without loss.
- rst mid-transfer: immediate return to IDLE with all reset values. The cmd_valid drop without acceptance is permitted only under rst.

## Structure
- Shared package `tlk2711_pkg`: mode encodings (MODE_NORM=0, MODE_LOOP=1, MODE_KCODE=2) and the state enum.
- One sub-module, `tlk2711_pkt_addr_gen`: running address/length/last generator with a load/advance interface.
- The scheduler FSM, counters and length check live in the top module.

## Test plan
- base=0x1000_0000, body=870, num=3, tail=100, total=2710, mode 0, ready=1 → commands (0x1000_0000,870), (0x1000_0366,870), (0x1000_06CC,870), (0x1000_0A32,100,last). After 4 pkt_done, a single interrupt pulse.
- Same config, pkt_done withheld, MAX_OUTSTANDING=2 → exactly 2 commands accepted, then valid low. Each pkt_done releases one more command.
- total=2711 (mismatch) → o_cfg_err=1, no commands, no interrupt, o_busy low by C+2.
- mode=2 → o_kcode_en=1, o_tx_mode=2, no commands, no interrupt. A following mode-0 config clears o_kcode_en.
- Random ready backpressure and config_done mid-transfer → addr/len stable while valid, second config ignored, o_cfg_err=1, original transfer completes.
- base=0xFFFF_FE00, body=870, num=2, tail=0, total=1740 → second addr 0x0000_0166 (wrap). rst asserted after first accept → all outputs at reset values next cycle.
